// File: rtl/traffic_pkg.sv
// Shared constants, types and segment helpers for the traffic countdown display.
package traffic_pkg;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit slot assignment on the 4-digit display
  localparam logic [1:0] DIG_G1_UNITS = 2'd0;
  localparam logic [1:0] DIG_G1_TENS  = 2'd1;
  localparam logic [1:0] DIG_G2_UNITS = 2'd2;
  localparam logic [1:0] DIG_G2_TENS  = 2'd3;

  // Number of shift/add-3 iterations for an 8-bit input
  localparam int BCD_ITERS = 8;

  // Converted value of one light: hundreds, tens, units
  typedef struct packed {
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } bcd_val_t;

  // Conversion sequencer: g1 first, then g2
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_CONV1 = 2'd1,
    SEQ_CONV2 = 2'd2
  } seq_state_t;

  // One decimal digit to its segment pattern; non-decimal codes go dark
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Pattern for one digit of a light: dashes when >= 100, leading tens zero blanked
  function automatic logic [6:0] light_seg(input bcd_val_t v, input logic tens_sel);
    logic [6:0] s;
    if (v.h != 2'd0) begin
      s = SEG_DASH;
    end else if (tens_sel) begin
      s = (v.t == 4'd0) ? SEG_BLANK : bcd_to_seg(v.t);
    end else begin
      s = bcd_to_seg(v.u);
    end
    return s;
  endfunction

endpackage

// File: rtl/traffic_seg_scan_bin2bcd.sv
// Sequential 8-bit binary to BCD converter (double dabble, one bit per cycle).
// The shift register latches the operand on start, so it doubles as the operand snapshot.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic       clk_fst,
  input  logic       rst,
  input  logic [7:0] bin,
  input  logic       start,
  output logic [1:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u,
  output logic       busy,
  output logic       done
);

  // {hundreds[17:16], tens[15:12], units[11:8], binary[7:0]}
  logic [17:0] sr_reg;
  logic [17:0] sr_next;
  logic [2:0]  iter_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [17:0] adj;

  // One iteration: add 3 to any BCD nibble >= 5, then shift left
  always_comb begin
    adj = sr_reg;
    if (adj[11:8] >= 4'd5) begin
      adj[11:8] = adj[11:8] + 4'd3;
    end
    if (adj[15:12] >= 4'd5) begin
      adj[15:12] = adj[15:12] + 4'd3;
    end
    sr_next = {adj[16:0], 1'b0};
  end

  // Iteration control; done pulses the cycle after the final iteration
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      sr_reg   <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg) begin
        sr_reg   <= sr_next;
        iter_reg <= iter_reg + 3'd1;
        if (iter_reg == 3'(BCD_ITERS - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end else if (start) begin
        sr_reg   <= {10'd0, bin};
        iter_reg <= '0;
        busy_reg <= 1'b1;
      end
    end
  end

  assign bcd_h = sr_reg[17:16];
  assign bcd_t = sr_reg[15:12];
  assign bcd_u = sr_reg[11:8];
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: rtl/traffic_seg_scan.sv
// 4-digit multiplexed 7-segment display of the two green countdowns.
// Values are sampled once per frame, converted to BCD in the background and
// shown from the following frame on; each digit slot starts with a dark guard time.
module traffic_seg_scan
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2
) (
  input  logic       clk_fst,
  input  logic       rst,
  input  logic [7:0] g1_cnt,
  input  logic [7:0] g2_cnt,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  logic [15:0] div_cnt_reg;
  logic [1:0]  digit_reg;
  logic        frame_start;

  logic [7:0]  snap2_reg;
  seq_state_t  state_reg, state_next;

  logic        conv_start;
  logic [7:0]  conv_bin;
  logic        conv_busy;
  logic        conv_done;
  bcd_val_t    conv_bcd;
  logic        pend1_load;
  logic        pend2_load;

  bcd_val_t    pend1_reg, pend2_reg;
  bcd_val_t    comm1_reg, comm2_reg;

  logic [6:0]  seg_next;
  logic [3:0]  an_next;
  logic [6:0]  seg_reg;
  logic [3:0]  an_reg;
  logic        frame_tick_reg;

  assign frame_start = (digit_reg == DIG_G1_UNITS) && (div_cnt_reg == 16'd0);

  // Slot divider and digit index
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      digit_reg   <= '0;
    end else if (div_cnt_reg == 16'(SCAN_DIV - 1)) begin
      div_cnt_reg <= '0;
      digit_reg   <= digit_reg + 2'd1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 16'd1;
    end
  end

  // g2 is held for the second conversion; g1 is latched inside the converter
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      snap2_reg <= '0;
    end else if (frame_start) begin
      snap2_reg <= g2_cnt;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk_fst (clk_fst),
    .rst     (rst),
    .bin     (conv_bin),
    .start   (conv_start),
    .bcd_h   (conv_bcd.h),
    .bcd_t   (conv_bcd.t),
    .bcd_u   (conv_bcd.u),
    .busy    (conv_busy),
    .done    (conv_done)
  );

  // Sequencer state register
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sequencer: g1 starts at frame start, g2 starts on the cycle g1 completes
  always_comb begin
    state_next = state_reg;
    conv_start = 1'b0;
    conv_bin   = snap2_reg;
    pend1_load = 1'b0;
    pend2_load = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (frame_start && !conv_busy) begin
          conv_start = 1'b1;
          conv_bin   = g1_cnt;
          state_next = SEQ_CONV1;
        end
      end
      SEQ_CONV1: begin
        if (conv_done) begin
          pend1_load = 1'b1;
          conv_start = 1'b1;
          conv_bin   = snap2_reg;
          state_next = SEQ_CONV2;
        end
      end
      SEQ_CONV2: begin
        if (conv_done) begin
          pend2_load = 1'b1;
          state_next = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Pending results fill during a frame; committed pair changes only at frame start
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      pend1_reg <= '0;
      pend2_reg <= '0;
      comm1_reg <= '0;
      comm2_reg <= '0;
    end else begin
      if (pend1_load) begin
        pend1_reg <= conv_bcd;
      end
      if (pend2_load) begin
        pend2_reg <= conv_bcd;
      end
      if (frame_start) begin
        comm1_reg <= pend1_reg;
        comm2_reg <= pend2_reg;
      end
    end
  end

  // Next segment pattern and anode enable for the current slot
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'b1111;
    case (digit_reg)
      DIG_G1_UNITS: seg_next = light_seg(comm1_reg, 1'b0);
      DIG_G1_TENS:  seg_next = light_seg(comm1_reg, 1'b1);
      DIG_G2_UNITS: seg_next = light_seg(comm2_reg, 1'b0);
      DIG_G2_TENS:  seg_next = light_seg(comm2_reg, 1'b1);
      default:      seg_next = SEG_BLANK;
    endcase
    if (!blank && (div_cnt_reg >= 16'(GUARD))) begin
      an_next = ~(4'b0001 << digit_reg);
    end
  end

  // Registered display outputs
  always_ff @(posedge clk_fst or negedge rst) begin
    if (!rst) begin
      seg_reg        <= SEG_BLANK;
      an_reg         <= 4'b1111;
      frame_tick_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_tick_reg <= frame_start;
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_traffic_seg_scan.sv
// Randomized bench for traffic_seg_scan against a frame-level behavioural model.
module tb_traffic_seg_scan;

  localparam int SD      = 32;
  localparam int GD      = 2;
  localparam int FR      = 4 * SD;
  localparam int RST_AT  = 30 * FR + 13;
  localparam int TOTAL   = RST_AT + 5 * FR;

  logic       clk_fst = 1'b0;
  logic       rst     = 1'b0;
  logic [7:0] g1_cnt  = 8'd0;
  logic [7:0] g2_cnt  = 8'd0;
  logic       blank   = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int checks   = 0;
  int failures = 0;
  int n;
  int vals1[$];
  int vals2[$];
  logic blank_prev;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk_fst = ~clk_fst;

  traffic_seg_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk_fst    (clk_fst),
    .rst        (rst),
    .g1_cnt     (g1_cnt),
    .g2_cnt     (g2_cnt),
    .blank      (blank),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  // Digit pattern for a countdown value as the display should render it
  function automatic logic [6:0] exp_seg(input int v, input bit tens);
    if (v >= 100) return 7'h40;
    if (tens) return (v / 10 == 0) ? 7'h00 : seg_tab[v / 10];
    return seg_tab[v % 10];
  endfunction

  function automatic logic [7:0] rand_val();
    int c;
    int edge_vals [6] = '{0, 9, 10, 99, 100, 255};
    c = $urandom_range(0, 3);
    case (c)
      0:       return 8'($urandom_range(0, 9));
      1:       return 8'($urandom_range(10, 99));
      2:       return 8'($urandom_range(100, 255));
      default: return 8'(edge_vals[$urandom_range(0, 5)]);
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h0);
    check({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  // Compare this cycle's outputs with the model; outputs show the previous cycle's position
  task automatic check_cycle();
    int p, slot, off, f, d1, d2, v;
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    if (n == 0) begin
      check_reset_outputs("first");
    end else begin
      p    = n - 1;
      slot = (p / SD) % 4;
      off  = p % SD;
      f    = p / FR;
      check("tick", 32'(frame_tick), 32'((p % FR) == 0));
      exp_an = (blank_prev || off < GD) ? 4'hF : ~(4'b0001 << slot);
      check("an", 32'(an), 32'(exp_an));
      if (off >= GD) begin
        d1 = (f == 0) ? 0 : vals1[f-1];
        d2 = (f == 0) ? 0 : vals2[f-1];
        v  = (slot < 2) ? d1 : d2;
        exp_s = exp_seg(v, slot[0]);
        check("seg", 32'(seg), 32'(exp_s));
      end
    end
  endtask

  // Stimulus schedule: directed frames, then random traffic with blanking
  task automatic drive(input int t);
    int fr, off;
    fr  = t / FR;
    off = t % FR;
    if (t > RST_AT || (fr >= 10 && fr < 29)) begin
      if ($urandom_range(0, 39) == 0) g1_cnt = rand_val();
      if ($urandom_range(0, 39) == 0) g2_cnt = rand_val();
      if ($urandom_range(0, 59) == 0) blank = ~blank;
    end else if (fr < 3) begin
      g1_cnt = 8'd57; g2_cnt = 8'd9; blank = 1'b0;
    end else if (fr < 5) begin
      g1_cnt = 8'd100; g2_cnt = 8'd255; blank = 1'b0;
    end else if (fr < 7) begin
      g1_cnt = 8'd99; g2_cnt = 8'd0; blank = 1'b0;
    end else if (fr < 10) begin
      g1_cnt = (fr == 7 && off < 60) ? 8'd20 : 8'd19;
      g2_cnt = 8'd42;
      blank  = (fr == 8 && off >= 40 && off < 80);
    end else begin
      g1_cnt = 8'd77; g2_cnt = 8'd88; blank = 1'b0;
    end
  endtask

  initial begin
    blank_prev = 1'b0;
    n = 0;
    repeat (3) @(negedge clk_fst);
    check_reset_outputs("in_reset");
    rst = 1'b1;
    for (int t = 0; t < TOTAL; t++) begin
      check_cycle();
      drive(t);
      if (n % FR == 0) begin
        vals1.push_back(int'(g1_cnt));
        vals2.push_back(int'(g2_cnt));
      end
      blank_prev = blank;
      if (t == RST_AT) begin
        // Reset lands while the g2 conversion is in flight
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (4) begin
          @(negedge clk_fst);
          check_reset_outputs("hold_rst");
        end
        rst = 1'b1;
        n = 0;
        vals1.delete();
        vals2.delete();
      end else begin
        n++;
        @(negedge clk_fst);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
